// File: rtl/hit_memory_pkg.sv
// Shared parameters, FSM encoding and hit payload for the hit memory readout block.
package hit_memory_pkg;

    localparam int unsigned WORDLENGTH   = 16;
    localparam int unsigned ROWINDEXBITS = 4;
    localparam int unsigned COLINDEXBITS = 4;
    localparam int unsigned COUNTBITS    = 2;
    localparam int unsigned MEMNROWS_HNM = 2 ** ROWINDEXBITS;
    localparam int unsigned ADDRBITS     = ROWINDEXBITS + COLINDEXBITS;
    localparam int unsigned HITSBITS     = ADDRBITS + 1;

    typedef enum logic [2:0] {
        IDLE,
        ROW_REQ,
        ROW_WAIT,
        SCAN,
        CNT_WAIT,
        EMIT,
        FINISH
    } state_t;

    typedef struct packed {
        logic [ADDRBITS-1:0]  addr;
        logic [COUNTBITS-1:0] count;
    } hit_t;

endpackage

// File: rtl/lowest_set_bit_encoder.sv
// Combinational priority encoder: reports whether any bit is set and the index of the lowest one.
module lowest_set_bit_encoder
    import hit_memory_pkg::*;
(
    input  logic [WORDLENGTH-1:0]   vec,
    output logic                    found,
    output logic [COLINDEXBITS-1:0] index
);

    // Descending walk so the lowest set bit is the last one to win.
    always_comb begin
        found = |vec;
        index = '0;
        for (int i = int'(WORDLENGTH) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                index = COLINDEXBITS'(i);
            end
        end
    end

endmodule

// File: rtl/hit_memory_readout.sv
// Walks the hits-new memory row by row, emits {address,count} for every set bit in ascending
// order on a valid/ready stream, and clears each HNM row and HCM entry once it has been served.
module hit_memory_readout
    import hit_memory_pkg::*;
(
    input  logic                    clock,
    input  logic                    resetN,
    input  logic                    startReadout,
    input  logic                    storageIdle,
    output logic [ROWINDEXBITS-1:0] hnmAddr,
    output logic                    hnmWe,
    output logic [WORDLENGTH-1:0]   hnmDin,
    input  logic [WORDLENGTH-1:0]   hnmDout,
    output logic [ADDRBITS-1:0]     hcmAddr,
    output logic                    hcmWe,
    output logic [COUNTBITS-1:0]    hcmDin,
    input  logic [COUNTBITS-1:0]    hcmDout,
    output logic                    hitValid,
    input  logic                    hitReady,
    output logic [ADDRBITS-1:0]     hitAddress,
    output logic [COUNTBITS-1:0]    hitCount,
    output logic                    busy,
    output logic                    done,
    output logic [HITSBITS-1:0]     hitsFound
);

    localparam logic [ROWINDEXBITS-1:0] LAST_ROW = ROWINDEXBITS'(MEMNROWS_HNM - 1);

    state_t                  state_q, state_d;
    logic [ROWINDEXBITS-1:0] row_q, row_d;
    logic [COLINDEXBITS-1:0] col_q, col_d;
    logic [WORDLENGTH-1:0]   row_buf_q, row_buf_d;
    hit_t                    hit_q, hit_d;
    logic                    hit_valid_q, hit_valid_d;
    logic [HITSBITS-1:0]     hits_found_q, hits_found_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [ROWINDEXBITS-1:0] hnm_addr_c;
    logic                    hnm_we_c;
    logic [ADDRBITS-1:0]     hcm_addr_c;
    logic                    hcm_we_c;

    logic                    lsb_found;
    logic [COLINDEXBITS-1:0] lsb_index;

    lowest_set_bit_encoder u_lsb (
        .vec   (row_buf_q),
        .found (lsb_found),
        .index (lsb_index)
    );

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            row_buf_q    <= '0;
            hit_q        <= '0;
            hit_valid_q  <= 1'b0;
            hits_found_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            row_buf_q    <= row_buf_d;
            hit_q        <= hit_d;
            hit_valid_q  <= hit_valid_d;
            hits_found_q <= hits_found_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // RAM port-A controls are decoded straight from state so the 1-cycle read latency lines up.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        row_buf_d    = row_buf_q;
        hit_d        = hit_q;
        hit_valid_d  = hit_valid_q;
        hits_found_d = hits_found_q;
        done_d       = 1'b0;
        hnm_addr_c   = '0;
        hnm_we_c     = 1'b0;
        hcm_addr_c   = '0;
        hcm_we_c     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (startReadout && storageIdle) begin
                    row_d        = '0;
                    hits_found_d = '0;
                    state_d      = ROW_REQ;
                end
            end
            ROW_REQ: begin
                hnm_addr_c = row_q;
                state_d    = ROW_WAIT;
            end
            ROW_WAIT: begin
                row_buf_d = hnmDout;
                state_d   = SCAN;
            end
            SCAN: begin
                if (!lsb_found) begin
                    // Row fully served: clear it, then move on or finish.
                    hnm_addr_c = row_q;
                    hnm_we_c   = 1'b1;
                    if (row_q == LAST_ROW) begin
                        state_d = FINISH;
                    end else begin
                        row_d   = row_q + ROWINDEXBITS'(1);
                        state_d = ROW_REQ;
                    end
                end else begin
                    hcm_addr_c = {row_q, lsb_index};
                    col_d      = lsb_index;
                    row_buf_d  = row_buf_q & ~(WORDLENGTH'(1) << lsb_index);
                    state_d    = CNT_WAIT;
                end
            end
            CNT_WAIT: begin
                hit_d.addr  = {row_q, col_q};
                hit_d.count = hcmDout;
                hit_valid_d = 1'b1;
                state_d     = EMIT;
            end
            EMIT: begin
                if (hitReady) begin
                    hit_valid_d  = 1'b0;
                    hcm_addr_c   = hit_q.addr;
                    hcm_we_c     = 1'b1;
                    hits_found_d = hits_found_q + HITSBITS'(1);
                    state_d      = SCAN;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign hnmAddr    = hnm_addr_c;
    assign hnmWe      = hnm_we_c;
    assign hnmDin     = '0;
    assign hcmAddr    = hcm_addr_c;
    assign hcmWe      = hcm_we_c;
    assign hcmDin     = '0;
    assign hitValid   = hit_valid_q;
    assign hitAddress = hit_q.addr;
    assign hitCount   = hit_q.count;
    assign busy       = busy_q;
    assign done       = done_q;
    assign hitsFound  = hits_found_q;

endmodule
